// File: rtl/ps2_key_event_ctrl_if.sv
// Scancode-in / key-event-out bus of ps2_key_event_ctrl.
// The master side is the controller; the slave side is the receiver plus consumer.
interface ps2_key_event_ctrl_if;
    logic [7:0] byte_in;
    logic       byte_vld;
    logic [9:0] evt_data;
    logic       evt_rep;
    logic       evt_vld;
    logic       evt_rdy;

    modport master (
        input  byte_in, byte_vld, evt_rdy,
        output evt_data, evt_rep, evt_vld
    );

    modport slave (
        output byte_in, byte_vld, evt_rdy,
        input  evt_data, evt_rep, evt_vld
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scancode sequencer: E0/F0 prefix decode, held-key tracking, event FIFO.
// Define KEY_REPEAT_EN to push typematic repeats with evt_rep=1; otherwise they are dropped.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   fpgaclk,
    input  logic                   rst,
    ps2_key_event_ctrl_if.master   bus,
    output logic [7:0]             held_code,
    output logic                   held_ext,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC);
`ifdef KEY_REPEAT_EN
    localparam int EW = 11;
`else
    localparam int EW = 10;
`endif

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            evt_gen, gen_ext, gen_brk;
    logic [7:0]      gen_code;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        evt_gen  = 1'b0;
        gen_ext  = 1'b0;
        gen_brk  = 1'b0;
        gen_code = bus.byte_in;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.byte_vld) begin
                    case (bus.byte_in)
                        8'hE0: state_d = EXT;
                        8'hF0: state_d = BRK;
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: ;
                        default: evt_gen = 1'b1;
                    endcase
                end
            end
            EXT: begin
                if (bus.byte_vld) begin
                    cnt_d = '0;
                    if (bus.byte_in == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (bus.byte_in != 8'hE0) begin
                        evt_gen = 1'b1;
                        gen_ext = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BRK: begin
                if (bus.byte_vld) begin
                    evt_gen = 1'b1;
                    gen_brk = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (bus.byte_vld) begin
                    evt_gen = 1'b1;
                    gen_ext = 1'b1;
                    gen_brk = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
        // A waiting prefix that sees no byte ages; a byte arriving on the last cycle still wins.
        if (state_q != IDLE && !bus.byte_vld) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    logic is_rep, make_new, brk_match, push_req;
    logic [EW-1:0] push_entry;

    assign is_rep    = evt_gen && !gen_brk && (held_code != 8'h00) &&
                       ({gen_ext, gen_code} == {held_ext, held_code});
    assign make_new  = evt_gen && !gen_brk && !is_rep;
    assign brk_match = evt_gen && gen_brk && ({gen_ext, gen_code} == {held_ext, held_code});
`ifdef KEY_REPEAT_EN
    assign push_req   = evt_gen;
    assign push_entry = {is_rep, gen_ext, gen_brk, gen_code};
`else
    assign push_req   = evt_gen && !is_rep;
    assign push_entry = {gen_ext, gen_brk, gen_code};
`endif

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, push_ok, ovf_set;
    logic [EW-1:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.evt_rdy;
    assign push_ok = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    assign bus.evt_vld  = !empty;
    assign bus.evt_data = empty ? 10'h000 : head[9:0];
`ifdef KEY_REPEAT_EN
    assign bus.evt_rep  = !empty && head[10];
`else
    assign bus.evt_rep  = 1'b0;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fpgaclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_code <= 8'h00;
            held_ext  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (make_new) begin
                held_code <= gen_code;
                held_ext  <= gen_ext;
            end else if (brk_match) begin
                held_code <= 8'h00;
                held_ext  <= 1'b0;
            end
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // NOTE: storage is not reset; the pointers define validity and the head is masked when empty.
    always_ff @(posedge fpgaclk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Randomized + directed bench for ps2_key_event_ctrl against a prefix-queue event model.
// Honours KEY_REPEAT_EN the same way as the design.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TOUT  = 200;

    logic       fpgaclk = 1'b0;
    logic       rst     = 1'b0;
    logic [7:0] held_code;
    logic       held_ext;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    ps2_key_event_ctrl_if bus ();

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .fpgaclk   (fpgaclk),
        .rst       (rst),
        .bus       (bus),
        .held_code (held_code),
        .held_ext  (held_ext),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #10 fpgaclk = ~fpgaclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: pending prefix bytes, expected event queue {rep,ext,brk,code}, held key, sticky flag.
    logic [7:0]  pfx [$];
    logic [10:0] mq  [$];
    logic [7:0]  m_code;
    logic        m_ext;
    logic        m_ovf;
    int          m_wait;

    function automatic bit is_ignored(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1};
    endfunction

    function automatic bit pfx_has(input logic [7:0] b);
        foreach (pfx[i]) if (pfx[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pfx.delete();
        mq.delete();
        m_code = 8'h00;
        m_ext  = 1'b0;
        m_ovf  = 1'b0;
        m_wait = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
        bit          push = 1'b0;
        bit          ovf_set = 1'b0;
        logic [10:0] ent = '0;
        if (v) begin
            m_wait = 0;
            if (pfx.size() == 0 && is_ignored(b)) begin
                // dropped silently
            end else if ((b == 8'hE0 || b == 8'hF0) && !pfx_has(8'hF0)) begin
                pfx.push_back(b);
            end else begin
                bit e = pfx_has(8'hE0);
                bit k = pfx_has(8'hF0);
                pfx.delete();
                if (k) begin
                    if (e == m_ext && b == m_code) begin
                        m_code = 8'h00;
                        m_ext  = 1'b0;
                    end
                    push = 1'b1;
                    ent  = {1'b0, e, 1'b1, b};
                end else if (m_code != 8'h00 && e == m_ext && b == m_code) begin
`ifdef KEY_REPEAT_EN
                    push = 1'b1;
                    ent  = {1'b1, e, 1'b0, b};
`endif
                end else begin
                    m_code = b;
                    m_ext  = e;
                    push   = 1'b1;
                    ent    = {1'b0, e, 1'b0, b};
                end
            end
        end else if (pfx.size() != 0) begin
            m_wait++;
            if (m_wait == TOUT) begin
                pfx.delete();
                m_wait = 0;
            end
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (mq.size() == DEPTH) ovf_set = 1'b1;
            else mq.push_back(ent);
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [10:0] h = (mq.size() > 0) ? mq[0] : 11'h000;
        check("evt_vld",   32'(bus.evt_vld),  32'(mq.size() > 0));
        check("evt_data",  32'(bus.evt_data), 32'(h[9:0]));
        check("evt_rep",   32'(bus.evt_rep),  32'(h[10]));
        check("held_code", 32'(held_code),    32'(m_code));
        check("held_ext",  32'(held_ext),     32'(m_ext));
        check("ovf",       32'(ovf),          32'(m_ovf));
    endtask

    // Called at a negedge: drive inputs, advance model, cross the posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
        bus.byte_vld = v;
        bus.byte_in  = v ? b : 8'($urandom);
        bus.evt_rdy  = rdy;
        ovf_clr      = clr;
        model_step(v, b, rdy, clr);
        @(posedge fpgaclk);
        @(negedge fpgaclk);
        compare_outputs();
    endtask

    logic tb_rdy = 1'b1;

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, tb_rdy, 1'b0);
        cycle(1'b0, 8'h00, tb_rdy, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, tb_rdy, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_evt_vld",   32'(bus.evt_vld),  32'h0);
        check("rst_evt_data",  32'(bus.evt_data), 32'h0);
        check("rst_evt_rep",   32'(bus.evt_rep),  32'h0);
        check("rst_held_code", 32'(held_code),    32'h0);
        check("rst_held_ext",  32'(held_ext),     32'h0);
        check("rst_ovf",       32'(ovf),          32'h0);
    endtask

    initial begin
        logic [7:0] keys [6];
        keys = '{8'h1C, 8'h1D, 8'h30, 8'h31, 8'h75, 8'h6B};
        bus.byte_vld = 1'b0;
        bus.byte_in  = 8'h00;
        bus.evt_rdy  = 1'b1;
        model_reset();
        #5;
        check_reset_outputs();
        @(negedge fpgaclk);
        @(negedge fpgaclk);
        rst = 1'b1;

        // Make then break; make, repeat, break; extended make and break.
        send(8'h30); send(8'hF0); send(8'h30);
        send(8'h31); send(8'h31); send(8'hF0); send(8'h31);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hE0); send(8'h6B); send(8'hF0); send(8'hE0);

        // Fill with the consumer stalled, push+pop when full, overflow, clear.
        tb_rdy = 1'b0;
        send(8'h15); send(8'h16); send(8'h1C); send(8'h1D);
        cycle(1'b1, 8'h24, 1'b1, 1'b0);
        send(8'h2B);
        cycle(1'b1, 8'h2C, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        tb_rdy = 1'b1;
        idle(6);

        // Prefix aging: byte on the last allowed cycle still completes, one later does not.
        cycle(1'b1, 8'hF0, 1'b1, 1'b0); idle(TOUT - 1); send(8'h1C);
        cycle(1'b1, 8'hE0, 1'b1, 1'b0); idle(TOUT);     send(8'h1C);
        send(8'hF0); idle(3 * TOUT); send(8'h1C);
        send(8'hAA); send(8'hFA);

        // Asynchronous reset mid-sequence with events still queued.
        tb_rdy = 1'b0;
        send(8'h33); send(8'h34);
        cycle(1'b1, 8'hF0, 1'b0, 1'b0);
        bus.byte_vld = 1'b0;
        #3 rst = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge fpgaclk);
        check_reset_outputs();
        rst = 1'b1;
        tb_rdy = 1'b1;
        send(8'h1C);

        // Randomized traffic with stall bursts.
        for (int n = 0; n < 4000; n++) begin
            int          r = $urandom_range(0, 99);
            logic [7:0]  b;
            logic        v = ($urandom_range(0, 2) == 0);
            if (r < 15)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 38) begin
                case ($urandom_range(0, 6))
                    0: b = 8'hAA; 1: b = 8'hFA; 2: b = 8'hFE; 3: b = 8'hEE;
                    4: b = 8'h00; 5: b = 8'hFF; default: b = 8'hE1;
                endcase
            end else b = keys[$urandom_range(0, 5)];
            if ($urandom_range(0, 49) == 0) tb_rdy = ~tb_rdy;
            cycle(v, b, tb_rdy & ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 499) == 0) idle(TOUT + 5);
        end
        tb_rdy = 1'b1;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
